stream_watchdog_multi: RTL

Parametrised multi-channel ready-valid watchdog for simulation and FPGA debug. It monitors NumChannels handshakes and flags any channel that is inactive (mode 0) or stalled with valid held (mode 1) for NumCycles consecutive cycles. Each channel has a per-channel enable, and trip flags are sticky. A trip timestamp and the index of the first tripped channel are reported. The block instantiates next to stream interfaces under test and is observe-only: it never drives the monitored handshake.

---
 rtl/stream_watchdog_multi.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stream_watchdog_multi.sv
// Multi-channel ready/valid watchdog: flags channels idle (StallMode=0) or stalled (StallMode=1) for NumCycles cycles.
// Latency: all outputs registered; a trip shows on the edge ending the NumCycles-th consecutive qualifying cycle.
// Observe-only, never drives the monitored handshake. STREAM_WATCHDOG_FATAL_EN: $fatal in simulation on each trip.
module stream_watchdog_multi #(
    parameter int NumChannels = 4,
    parameter int NumCycles   = 1000,
    parameter int StallMode   = 0,
    parameter int TsWidth     = 32,
    localparam int IdxWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumChannels-1:0] en_i,
    input  logic                   clear_i,
    input  logic [NumChannels-1:0] valid_i,
    input  logic [NumChannels-1:0] ready_i,
    output logic [NumChannels-1:0] tripped_o,
    output logic                   any_tripped_o,
    output logic [IdxWidth-1:0]    first_idx_o,
    output logic [TsWidth-1:0]     trip_time_o
);

    localparam int CntW = (NumCycles >= 1) ? $clog2(NumCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(NumCycles);

    if (NumCycles < 1) begin : g_bad_cycles
        $error("stream_watchdog_multi: NumCycles must be >= 1");
    end
    if (NumChannels < 1) begin : g_bad_channels
        $error("stream_watchdog_multi: NumChannels must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ARMED, TRIPPED} state_e;

    state_e                 state_q [NumChannels];
    logic [CntW-1:0]        cnt_q   [NumChannels];
    logic [TsWidth-1:0]     cyc_q;
    logic [NumChannels-1:0] reload;
    logic [NumChannels-1:0] trip_now;
    logic [IdxWidth-1:0]    low_idx;

    // A handshake (or, when stall-counting, an absent valid) restarts the count.
    // Anything else qualifies, so an unknown handshake falls through to counting.
    always_comb begin
        reload   = '0;
        trip_now = '0;
        for (int c = 0; c < NumChannels; c++) begin
            if (valid_i[c] & ready_i[c]) begin
                reload[c] = 1'b1;
            end else if ((StallMode != 0) && !(valid_i[c] & !ready_i[c])) begin
                reload[c] = 1'b1;
            end
            trip_now[c] = !clear_i && (state_q[c] == ARMED) && en_i[c] &&
                          !reload[c] && (cnt_q[c] == CntW'(1));
        end
    end

    always_comb begin
        low_idx = '0;
        for (int c = NumChannels - 1; c >= 0; c--) begin
            if (trip_now[c]) begin
                low_idx = IdxWidth'(c);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= CntLoad;
            end
            cyc_q         <= '0;
            tripped_o     <= '0;
            any_tripped_o <= 1'b0;
            first_idx_o   <= '0;
            trip_time_o   <= '0;
        end else begin
            if (cyc_q != '1) begin
                cyc_q <= cyc_q + TsWidth'(1);
            end
            if (clear_i) begin
                for (int c = 0; c < NumChannels; c++) begin
                    state_q[c] <= en_i[c] ? ARMED : IDLE;
                    cnt_q[c]   <= CntLoad;
                end
                tripped_o     <= '0;
                any_tripped_o <= 1'b0;
                first_idx_o   <= '0;
                trip_time_o   <= '0;
            end else begin
                for (int c = 0; c < NumChannels; c++) begin
                    case (state_q[c])
                        IDLE: begin
                            cnt_q[c] <= CntLoad;
                            if (en_i[c]) begin
                                state_q[c] <= ARMED;
                            end
                        end
                        ARMED: begin
                            if (!en_i[c]) begin
                                state_q[c] <= IDLE;
                                cnt_q[c]   <= CntLoad;
                            end else if (reload[c]) begin
                                cnt_q[c] <= CntLoad;
                            end else if (trip_now[c]) begin
                                state_q[c]   <= TRIPPED;
                                cnt_q[c]     <= CntLoad;
                                tripped_o[c] <= 1'b1;
                            end else begin
                                cnt_q[c] <= cnt_q[c] - CntW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                if (|trip_now) begin
                    any_tripped_o <= 1'b1;
                    // Only the first trip since reset/clear is timestamped.
                    if (!any_tripped_o) begin
                        first_idx_o <= low_idx;
                        trip_time_o <= cyc_q;
                    end
                end
            end
        end
    end

`ifdef STREAM_WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (rst_ni && trip_now[c]) begin
                $fatal(1, "%m: channel %0d tripped at time %0t after %0d cycles", c, $time, NumCycles);
            end
        end
    end
`endif
`else
    // Trips are reported through the outputs only.
`endif

endmodule
